// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
// Shares one single-port, write-first block RAM (1-cycle read latency)
// between two clients. Client 0 (latency-critical reader, e.g. scanout) has
// fixed priority. Client 1 (game logic) is guaranteed a grant after MAX_WAIT
// consecutive lost arbitrations.
//
// Ports
//   clk, rst_n                   clock, synchronous active-low reset
//   req0/we0/addr0/wdata0        client 0 request, write flag, address, data
//   gnt0                         client 0 accepted this cycle (combinational)
//   rvalid0/rdata0               client 0 read return (1 cycle after grant)
//   req1/we1/addr1/wdata1        client 1 request, write flag, address, data
//   gnt1, rvalid1, rdata1        client 1 grant and read return
//   ram_en/ram_we/ram_addr/ram_di  RAM control, driven by the granted client
//   ram_dout                     RAM read data
// ---------------------------------------------------------------------------
module ram_port_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_WAIT   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] wdata0,
   output logic                  gnt0,
   output logic                  rvalid0,
   output logic [DATA_WIDTH-1:0] rdata0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  gnt1,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_di,
   input  logic [DATA_WIDTH-1:0] ram_dout
);

   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   logic [7:0] r_wait_cnt;
   logic       r_rvalid0;
   logic       r_rvalid1;
   logic       w_gnt0;
   logic       w_gnt1;

   // Arbitration: client 0 wins contention unless client 1 has been starved
   // MAX_WAIT times in a row. Grants are suppressed while reset is held.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (!rst_n) begin
         w_gnt0 = 1'b0;
         w_gnt1 = 1'b0;
      end else if (req0 && req1) begin
         if (r_wait_cnt >= MAX_WAIT_C) begin
            w_gnt1 = 1'b1;
         end else begin
            w_gnt0 = 1'b1;
         end
      end else if (req0) begin
         w_gnt0 = 1'b1;
      end else if (req1) begin
         w_gnt1 = 1'b1;
      end else begin
         w_gnt0 = 1'b0;
         w_gnt1 = 1'b0;
      end
   end

   // RAM control mux from the granted client; all zero when idle.
   always_comb begin
      ram_en   = w_gnt0 | w_gnt1;
      ram_we   = 1'b0;
      ram_addr = {ADDR_WIDTH{1'b0}};
      ram_di   = {DATA_WIDTH{1'b0}};
      if (w_gnt0) begin
         ram_we   = we0;
         ram_addr = addr0;
         ram_di   = wdata0;
      end else if (w_gnt1) begin
         ram_we   = we1;
         ram_addr = addr1;
         ram_di   = wdata1;
      end else begin
         ram_we   = 1'b0;
         ram_addr = {ADDR_WIDTH{1'b0}};
         ram_di   = {DATA_WIDTH{1'b0}};
      end
   end

   // Starvation counter and read-valid pipeline.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wait_cnt <= 8'd0;
         r_rvalid0  <= 1'b0;
         r_rvalid1  <= 1'b0;
      end else begin
         r_rvalid0 <= w_gnt0 & ~we0;
         r_rvalid1 <= w_gnt1 & ~we1;
         if (req1 && !w_gnt1) begin
            if (r_wait_cnt >= MAX_WAIT_C) begin
               r_wait_cnt <= MAX_WAIT_C;
            end else begin
               r_wait_cnt <= r_wait_cnt + 8'd1;
            end
         end else begin
            r_wait_cnt <= 8'd0;
         end
      end
   end

   assign gnt0 = w_gnt0;
   assign gnt1 = w_gnt1;

   // Gating with rst_n kills a read issued the cycle before reset asserts:
   // its rvalid would otherwise appear during the first reset cycle.
   assign rvalid0 = r_rvalid0 & rst_n;
   assign rvalid1 = r_rvalid1 & rst_n;

   // Both clients see the RAM output directly; only valid under rvalid.
   assign rdata0 = ram_dout;
   assign rdata1 = ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
   localparam int AW = 8;
   localparam int DW = 8;
   localparam int MW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic req0, we0, req1, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic gnt0, gnt1, rvalid0, rvalid1;
   logic [DW-1:0] rdata0, rdata1;
   logic ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_di;
   logic [DW-1:0] ram_dout;

   ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
      .ram_dout(ram_dout)
   );

   // Single-port write-first RAM, 1-cycle read latency
   logic [DW-1:0] mem [256];
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) begin
            mem[ram_addr] <= ram_di;
            ram_dout      <= ram_di;
         end else begin
            ram_dout <= mem[ram_addr];
         end
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rn, input logic r0, input logic w0, input logic [7:0] a0,
                        input logic [7:0] d0, input logic r1, input logic w1,
                        input logic [7:0] a1, input logic [7:0] d1);
      rst_n = rn; req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
   endtask

   // advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic rn, r0, w0;
      logic [7:0] a0, d0;
      logic r1, w1;
      logic [7:0] a1, d1;
      logic g0, g1, v0, v1;
      logic [7:0] rd, wc;
   } vec_t;

   function automatic vec_t mk(input logic rn, input logic r0, input logic w0, input logic [7:0] a0,
                               input logic [7:0] d0, input logic r1, input logic w1,
                               input logic [7:0] a1, input logic [7:0] d1,
                               input logic g0, input logic g1, input logic v0, input logic v1,
                               input logic [7:0] rd, input logic [7:0] wc);
      vec_t v;
      v.rn = rn; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
      v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.rd = rd; v.wc = wc;
      return v;
   endfunction

   vec_t tbl [19];

   // reference model state
   int          losses;
   logic        pv0, pv1, pk;
   logic [7:0]  prd;
   logic [7:0]  shadow [16];
   logic        known [16];

   initial begin
      // rvalid expectations refer to the read granted in the previous row
      tbl[0]  = mk(0, 1,0,8'h10,8'h00, 1,0,8'h20,8'h00, 0,0,0,0,8'h00,8'd0);
      tbl[1]  = mk(1, 1,1,8'h10,8'hA5, 0,0,8'h00,8'h00, 1,0,0,0,8'h00,8'd0);
      tbl[2]  = mk(1, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 1,0,0,0,8'h00,8'd0);
      tbl[3]  = mk(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,1,0,8'hA5,8'd0);
      tbl[4]  = mk(1, 0,0,8'h00,8'h00, 1,1,8'h20,8'h3C, 0,1,0,0,8'h00,8'd0);
      tbl[5]  = mk(1, 0,0,8'h00,8'h00, 1,0,8'h20,8'h00, 0,1,0,0,8'h00,8'd0);
      tbl[6]  = mk(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,1,8'h3C,8'd0);
      tbl[7]  = mk(1, 1,0,8'h10,8'h00, 1,0,8'h20,8'h00, 1,0,0,0,8'h00,8'd0);
      tbl[8]  = mk(1, 1,0,8'h10,8'h00, 1,0,8'h20,8'h00, 1,0,1,0,8'hA5,8'd1);
      tbl[9]  = mk(1, 1,0,8'h10,8'h00, 1,0,8'h20,8'h00, 1,0,1,0,8'hA5,8'd2);
      tbl[10] = mk(1, 1,0,8'h10,8'h00, 1,0,8'h20,8'h00, 1,0,1,0,8'hA5,8'd3);
      tbl[11] = mk(1, 1,0,8'h10,8'h00, 1,0,8'h20,8'h00, 0,1,1,0,8'hA5,8'd4);
      tbl[12] = mk(1, 1,0,8'h10,8'h00, 1,0,8'h20,8'h00, 1,0,0,1,8'h3C,8'd0);
      tbl[13] = mk(1, 1,0,8'h10,8'h00, 1,0,8'h20,8'h00, 1,0,1,0,8'hA5,8'd1);
      tbl[14] = mk(1, 1,0,8'h10,8'h00, 1,0,8'h20,8'h00, 1,0,1,0,8'hA5,8'd2);
      tbl[15] = mk(1, 1,0,8'h10,8'h00, 1,0,8'h20,8'h00, 1,0,1,0,8'hA5,8'd3);
      tbl[16] = mk(1, 1,0,8'h10,8'h00, 1,0,8'h20,8'h00, 0,1,1,0,8'hA5,8'd4);
      tbl[17] = mk(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,1,8'h3C,8'd0);
      tbl[18] = mk(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0,8'h00,8'd0);

      drive(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00);
      step();
      step();

      // ---- table-driven directed vectors
      for (int i = 0; i < 19; i++) begin
         drive(tbl[i].rn, tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
               tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
         #1;
         chk($sformatf("tbl%0d_gnt0", i), 32'(gnt0), 32'(tbl[i].g0));
         chk($sformatf("tbl%0d_gnt1", i), 32'(gnt1), 32'(tbl[i].g1));
         chk($sformatf("tbl%0d_ram_en", i), 32'(ram_en), 32'(tbl[i].g0 | tbl[i].g1));
         chk($sformatf("tbl%0d_rvalid0", i), 32'(rvalid0), 32'(tbl[i].v0));
         chk($sformatf("tbl%0d_rvalid1", i), 32'(rvalid1), 32'(tbl[i].v1));
         chk($sformatf("tbl%0d_wait_cnt", i), 32'(dut.r_wait_cnt), 32'(tbl[i].wc));
         if (tbl[i].v0) chk($sformatf("tbl%0d_rdata0", i), 32'(rdata0), 32'(tbl[i].rd));
         if (tbl[i].v1) chk($sformatf("tbl%0d_rdata1", i), 32'(rdata1), 32'(tbl[i].rd));
         step();
      end

      // ---- back-to-back reads: preload 0x80+a at a=0..7, then read 8 in a row
      for (int a = 0; a < 8; a++) begin
         drive(1, 1,1,8'(a),8'(8'h80 + a), 0,0,8'h00,8'h00);
         #1;
         chk("b2b_wr_gnt0", 32'(gnt0), 32'd1);
         step();
      end
      for (int a = 0; a < 9; a++) begin
         if (a < 8) drive(1, 1,0,8'(a),8'h00, 0,0,8'h00,8'h00);
         else       drive(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00);
         #1;
         if (a < 8) begin
            chk("b2b_rd_gnt0", 32'(gnt0), 32'd1);
            chk("b2b_rd_ram_en", 32'(ram_en), 32'd1);
         end
         chk("b2b_rvalid0", 32'(rvalid0), (a > 0) ? 32'd1 : 32'd0);
         chk("b2b_rvalid1", 32'(rvalid1), 32'd0);
         if (a > 0) chk("b2b_rdata0", 32'(rdata0), 32'(8'h80 + a - 1));
         step();
      end

      // ---- reset right after a read grant
      drive(1, 1,0,8'h03,8'h00, 1,0,8'h04,8'h00);
      #1;
      chk("rst_rd_gnt0", 32'(gnt0), 32'd1);
      step();
      drive(0, 1,0,8'h03,8'h00, 1,0,8'h04,8'h00);
      #1;
      chk("rst_gnt0", 32'(gnt0), 32'd0);
      chk("rst_gnt1", 32'(gnt1), 32'd0);
      chk("rst_ram_en", 32'(ram_en), 32'd0);
      chk("rst_rvalid0_killed", 32'(rvalid0), 32'd0);
      step();
      #1;
      chk("rst2_rvalid0", 32'(rvalid0), 32'd0);
      chk("rst2_ram_en", 32'(ram_en), 32'd0);
      step();
      drive(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00);
      #1;
      chk("rel_rvalid0", 32'(rvalid0), 32'd0);
      chk("rel_wait_cnt", 32'(dut.r_wait_cnt), 32'd0);
      step();

      // ---- ten idle cycles
      for (int c = 0; c < 10; c++) begin
         #1;
         chk("idle_ram_en", 32'(ram_en), 32'd0);
         chk("idle_gnt", 32'({gnt0, gnt1}), 32'd0);
         chk("idle_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
         step();
      end

      // ---- randomized traffic against a reference model
      losses = 0; pv0 = 1'b0; pv1 = 1'b0; pk = 1'b0; prd = 8'h00;
      for (int k = 0; k < 16; k++) known[k] = 1'b0;
      for (int c = 0; c < 600; c++) begin
         logic rn, r0, w0, r1, w1, e0, e1, ew;
         logic [7:0] a0, d0, a1, d1, ea, ed;
         rn = ($urandom_range(0, 39) != 0);
         r0 = ($urandom_range(0, 2) == 0);
         r1 = ($urandom_range(0, 1) == 0);
         w0 = ($urandom_range(0, 1) == 0);
         w1 = ($urandom_range(0, 1) == 0);
         a0 = 8'($urandom_range(0, 15));
         a1 = 8'($urandom_range(0, 15));
         d0 = 8'($urandom);
         d1 = 8'($urandom);
         drive(rn, r0, w0, a0, d0, r1, w1, a1, d1);
         #1;
         // client 1 wins when uncontested or after MAX_WAIT straight losses
         e1 = rn && r1 && (!r0 || losses == MW);
         e0 = rn && r0 && !e1;
         ew = e0 ? w0 : (e1 ? w1 : 1'b0);
         ea = e0 ? a0 : (e1 ? a1 : 8'h00);
         ed = e0 ? d0 : (e1 ? d1 : 8'h00);
         chk("rnd_gnt0", 32'(gnt0), 32'(e0));
         chk("rnd_gnt1", 32'(gnt1), 32'(e1));
         chk("rnd_ram_ctl", {22'd0, ram_en, ram_we, ram_addr}, {22'd0, e0 | e1, ew, ea});
         chk("rnd_ram_di", 32'(ram_di), 32'(ed));
         chk("rnd_rvalid0", 32'(rvalid0), 32'(pv0 && rn));
         chk("rnd_rvalid1", 32'(rvalid1), 32'(pv1 && rn));
         if (pv0 && rn && pk) chk("rnd_rdata0", 32'(rdata0), 32'(prd));
         if (pv1 && rn && pk) chk("rnd_rdata1", 32'(rdata1), 32'(prd));
         // advance model to the state after this edge
         if (!rn)              losses = 0;
         else if (r1 && !e1)   losses = (losses < MW) ? losses + 1 : MW;
         else                  losses = 0;
         pv0 = e0 && !w0;
         pv1 = e1 && !w1;
         if (e0 || e1) begin
            if (ew) begin
               shadow[ea[3:0]] = ed;
               known[ea[3:0]]  = 1'b1;
            end else begin
               prd = shadow[ea[3:0]];
               pk  = known[ea[3:0]];
            end
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
